// File: rtl/jtpang_pkg.sv
// Shared definitions for the jtpang sound-ROM plumbing.
//   pcm_state_t : PCM slot request FSM (idle / request posted / awaiting data)
//   PCM_OFFSET  : SDRAM word offset of the PCM sample region, used by the game top
package jtpang_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } pcm_state_t;

  localparam logic [21:0] PCM_OFFSET = 22'h10000;

endpackage

// File: rtl/jtpang_pcm_slot.sv
// PCM sample ROM slot: byte-wide requester port in front of one SDRAM bank,
// with a one-word cache so both bytes of a word are served from one read.
//   clk, rst_n        : clock, async active-low reset
//   downloading       : ROM download in progress; flushes cache, blocks reads
//   cs, addr          : byte request from the sound block
//   dout, ok          : selected byte and its valid flag (combinational on hit)
//   sdram_addr/rd     : word read request towards the SDRAM controller
//   sdram_ack/rdy     : request accepted / data valid pulses
//   data_read         : 16-bit SDRAM read data
module jtpang_pcm_slot
  import jtpang_pkg::*;
#(
  parameter int          AW     = 18,
  parameter logic [21:0] OFFSET = 22'h0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          downloading,
  input  logic          cs,
  input  logic [AW-1:0] addr,
  output logic [7:0]    dout,
  output logic          ok,
  output logic [21:0]   sdram_addr,
  output logic          sdram_rd,
  input  logic          sdram_ack,
  input  logic          sdram_rdy,
  input  logic [15:0]   data_read
);

  pcm_state_t    state;
  logic          valid;
  logic          abort;
  logic [AW-2:0] tag;
  logic [AW-2:0] req_tag;
  logic [15:0]   word;
  logic          hit;

  assign hit  = cs & valid & ~downloading & (addr[AW-1:1] == tag);
  assign ok   = hit;
  assign dout = addr[0] ? word[15:8] : word[7:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      valid      <= 1'b0;
      abort      <= 1'b0;
      tag        <= '0;
      req_tag    <= '0;
      word       <= '0;
      sdram_rd   <= 1'b0;
      sdram_addr <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          abort <= 1'b0;
          if (cs && !hit && !downloading) begin
            req_tag    <= addr[AW-1:1];
            sdram_addr <= OFFSET + 22'(addr[AW-1:1]);  // wraps modulo 2^22
            sdram_rd   <= 1'b1;
            state      <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (downloading) abort <= 1'b1;
          if (sdram_ack) begin
            sdram_rd <= 1'b0;
            // ack and rdy together: treat as ack immediately followed by rdy
            if (sdram_rdy) begin
              word  <= data_read;
              tag   <= req_tag;
              valid <= ~abort;
              state <= ST_IDLE;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (downloading) abort <= 1'b1;
          if (sdram_rdy) begin
            word  <= data_read;
            tag   <= req_tag;
            valid <= ~abort;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
      // Overrides any fill above, so data landing in the same cycle that a
      // download starts is discarded as well.
      if (downloading) valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jtpang_pcm_slot.sv
module tb_jtpang_pcm_slot;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        downloading;
  logic        cs;
  logic [17:0] addr;
  logic [7:0]  dout;
  logic        ok;
  logic [21:0] sdram_addr;
  logic        sdram_rd;
  logic        sdram_ack;
  logic        sdram_rdy;
  logic [15:0] data_read;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  jtpang_pcm_slot #(.AW(18), .OFFSET(22'h10000)) dut (
    .clk(clk), .rst_n(rst_n), .downloading(downloading),
    .cs(cs), .addr(addr), .dout(dout), .ok(ok),
    .sdram_addr(sdram_addr), .sdram_rd(sdram_rd),
    .sdram_ack(sdram_ack), .sdram_rdy(sdram_rdy), .data_read(data_read)
  );

  // Advance one clock; inputs are then changed and outputs sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    downloading = 1'($urandom);
    cs          = 1'b1;
    addr        = 18'($urandom);
    sdram_ack   = 1'($urandom);
    sdram_rdy   = 1'($urandom);
    data_read   = 16'($urandom);
    tick(); tick();
    n_cmp++; if (ok !== 1'b0)       begin n_err++; $display("FAIL reset_ok got %b want 0", ok); end
    n_cmp++; if (sdram_rd !== 1'b0) begin n_err++; $display("FAIL reset_rd got %b want 0", sdram_rd); end
    n_cmp++; if (dout !== 8'h00)    begin n_err++; $display("FAIL reset_dout got %h want 00", dout); end
    n_cmp++; if (sdram_addr !== 22'h0) begin n_err++; $display("FAIL reset_addr got %h want 0", sdram_addr); end
    downloading = 1'b0; cs = 1'b0; sdram_ack = 1'b0; sdram_rdy = 1'b0;
    rst_n = 1'b1;
    tick();
    n_cmp++; if (ok !== 1'b0 || sdram_rd !== 1'b0 || dout !== 8'h00)
      begin n_err++; $display("FAIL post_reset got ok=%b rd=%b dout=%h want 0/0/00", ok, sdram_rd, dout); end
  endtask

  task automatic test_cold_miss();
    // cycle 0: request
    cs = 1'b1; addr = 18'h00105; #1;
    n_cmp++; if (ok !== 1'b0) begin n_err++; $display("FAIL miss_ok0 got %b want 0", ok); end
    for (int c = 1; c <= 3; c++) begin
      tick();
      if (c == 3) sdram_ack = 1'b1;
      n_cmp++; if (sdram_rd !== 1'b1) begin n_err++; $display("FAIL miss_rd_c%0d got %b want 1", c, sdram_rd); end
      n_cmp++; if (sdram_addr !== 22'h10082) begin n_err++; $display("FAIL miss_addr_c%0d got %h want 10082", c, sdram_addr); end
    end
    tick(); sdram_ack = 1'b0;  // cycle 4
    n_cmp++; if (sdram_rd !== 1'b0) begin n_err++; $display("FAIL miss_rd_drop got %b want 0", sdram_rd); end
    tick();                    // cycle 5
    tick();                    // cycle 6
    sdram_rdy = 1'b1; data_read = 16'hA55A; #1;
    n_cmp++; if (ok !== 1'b0) begin n_err++; $display("FAIL miss_ok_rdy got %b want 0", ok); end
    tick(); sdram_rdy = 1'b0; data_read = 16'h0000; #1;  // cycle 7
    n_cmp++; if (ok !== 1'b1 || dout !== 8'hA5)
      begin n_err++; $display("FAIL miss_fill got ok=%b dout=%h want 1/a5", ok, dout); end
  endtask

  task automatic test_same_word_hit();
    addr = 18'h00104; #1;
    n_cmp++; if (ok !== 1'b1 || dout !== 8'h5A)
      begin n_err++; $display("FAIL hit got ok=%b dout=%h want 1/5a", ok, dout); end
    tick();
    n_cmp++; if (sdram_rd !== 1'b0) begin n_err++; $display("FAIL hit_no_rd got %b want 0", sdram_rd); end
  endtask

  task automatic test_addr_change();
    addr = 18'h00200; #1;
    tick();
    n_cmp++; if (sdram_rd !== 1'b1 || sdram_addr !== 22'h10100)
      begin n_err++; $display("FAIL chg_rd1 got rd=%b addr=%h want 1/10100", sdram_rd, sdram_addr); end
    sdram_ack = 1'b1;
    tick(); sdram_ack = 1'b0;
    addr = 18'h00400; #1;
    n_cmp++; if (ok !== 1'b0) begin n_err++; $display("FAIL chg_ok_wait got %b want 0", ok); end
    tick();
    sdram_rdy = 1'b1; data_read = 16'hBEEF;
    tick(); sdram_rdy = 1'b0; #1;
    n_cmp++; if (ok !== 1'b0 || sdram_rd !== 1'b0)
      begin n_err++; $display("FAIL chg_after_fill got ok=%b rd=%b want 0/0", ok, sdram_rd); end
    tick();
    n_cmp++; if (sdram_rd !== 1'b1 || sdram_addr !== 22'h10200)
      begin n_err++; $display("FAIL chg_rd2 got rd=%b addr=%h want 1/10200", sdram_rd, sdram_addr); end
    sdram_ack = 1'b1;
    tick(); sdram_ack = 1'b0;
    sdram_rdy = 1'b1; data_read = 16'hCAFE;
    tick(); sdram_rdy = 1'b0; #1;
    n_cmp++; if (ok !== 1'b1 || dout !== 8'hFE)
      begin n_err++; $display("FAIL chg_fill2 got ok=%b dout=%h want 1/fe", ok, dout); end
  endtask

  task automatic test_download_flush();
    // cache holds word 0x200; start a read for word 0x280
    addr = 18'h00500; #1;
    tick();
    n_cmp++; if (sdram_rd !== 1'b1 || sdram_addr !== 22'h10280)
      begin n_err++; $display("FAIL dl_rd1 got rd=%b addr=%h want 1/10280", sdram_rd, sdram_addr); end
    sdram_ack = 1'b1;
    tick(); sdram_ack = 1'b0;
    downloading = 1'b1; addr = 18'h00400; #1;  // previously cached word
    n_cmp++; if (ok !== 1'b0) begin n_err++; $display("FAIL dl_ok_d0 got %b want 0", ok); end
    tick();
    sdram_rdy = 1'b1; data_read = 16'h1111; #1;
    n_cmp++; if (ok !== 1'b0) begin n_err++; $display("FAIL dl_ok_d1 got %b want 0", ok); end
    tick(); sdram_rdy = 1'b0; #1;
    for (int d = 2; d <= 3; d++) begin
      n_cmp++; if (ok !== 1'b0 || sdram_rd !== 1'b0)
        begin n_err++; $display("FAIL dl_d%0d got ok=%b rd=%b want 0/0", d, ok, sdram_rd); end
      tick();
    end
    downloading = 1'b0; addr = 18'h00500; #1;
    n_cmp++; if (ok !== 1'b0) begin n_err++; $display("FAIL dl_discard got ok=%b want 0", ok); end
    tick();
    n_cmp++; if (sdram_rd !== 1'b1 || sdram_addr !== 22'h10280)
      begin n_err++; $display("FAIL dl_reissue got rd=%b addr=%h want 1/10280", sdram_rd, sdram_addr); end
    sdram_ack = 1'b1;
    tick(); sdram_ack = 1'b0;
    sdram_rdy = 1'b1; data_read = 16'h7788;
    tick(); sdram_rdy = 1'b0; #1;
    n_cmp++; if (ok !== 1'b1 || dout !== 8'h88)
      begin n_err++; $display("FAIL dl_refill got ok=%b dout=%h want 1/88", ok, dout); end
  endtask

  task automatic test_ack_rdy_same();
    addr = 18'h00600; #1;
    tick();
    n_cmp++; if (sdram_rd !== 1'b1 || sdram_addr !== 22'h10300)
      begin n_err++; $display("FAIL ar_rd got rd=%b addr=%h want 1/10300", sdram_rd, sdram_addr); end
    sdram_ack = 1'b1; sdram_rdy = 1'b1; data_read = 16'h1234;
    tick(); sdram_ack = 1'b0; sdram_rdy = 1'b0; data_read = 16'h0000; #1;
    n_cmp++; if (sdram_rd !== 1'b0 || ok !== 1'b1 || dout !== 8'h34)
      begin n_err++; $display("FAIL ar_fill got rd=%b ok=%b dout=%h want 0/1/34", sdram_rd, ok, dout); end
    tick();
    n_cmp++; if (sdram_rd !== 1'b0) begin n_err++; $display("FAIL ar_idle got rd=%b want 0", sdram_rd); end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_same_word_hit();
    test_addr_change();
    test_download_flush();
    test_ack_rdy_same();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
